// File: rtl/gpio_bank.sv
// -----------------------------------------------------------------------------
// gpio_bank
//
// Multi-channel GPIO peripheral sitting between the CPU load/store path and
// the board pins. Each channel has:
//   OUT    (addr[1:0]=0) rw   registered value driven on gpio_out
//   IN     (addr[1:0]=1) ro   synchronised + debounced pin value
//   MASK   (addr[1:0]=2) rw   interrupt enable per bit
//   STATUS (addr[1:0]=3) w1c  set on any edge of the matching IN bit
// addr[AW-1:2] selects the channel; channels >= CHANNELS read as 0 and
// ignore writes.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   gpio_in         raw pins, channel c = bits [c*WIDTH +: WIDTH]
//   gpio_out        registered output pins, same packing
//   wr_en, rd_en    register write / read strobes
//   addr, wdata     register address and write data
//   rdata, rvalid   read data, valid for one cycle after an accepted rd_en
//   irq             OR over channels of (STATUS & MASK)
// -----------------------------------------------------------------------------
module gpio_bank #(
    parameter  int WIDTH       = 32,
    parameter  int CHANNELS    = 2,
    parameter  int SYNC_STAGES = 2,
    parameter  int DEBOUNCE    = 4,
    localparam int AW          = $clog2(CHANNELS) + 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*WIDTH-1:0]    gpio_in,
    output logic [CHANNELS*WIDTH-1:0]    gpio_out,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [AW-1:0]                addr,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         rvalid,
    output logic                         irq
);

    localparam int CNTW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        REG_OUT    = 2'd0,
        REG_IN     = 2'd1,
        REG_MASK   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    logic [AW-1:0]               addr_ch;
    reg_sel_e                    sel;
    logic [CHANNELS-1:0]         ch_hit;
    logic [CHANNELS-1:0]         ch_irq;
    logic [CHANNELS*WIDTH-1:0]   out_all;
    logic [CHANNELS*WIDTH-1:0]   in_all;
    logic [CHANNELS*WIDTH-1:0]   mask_all;
    logic [CHANNELS*WIDTH-1:0]   status_all;
    logic [WIDTH-1:0]            rd_mux;

    // Channel index; with a single channel this is always zero.
    assign addr_ch = addr >> 2;
    assign sel     = reg_sel_e'(addr[1:0]);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic             wr_hit;
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] in_q;
        logic [WIDTH-1:0] in_d;
        logic [CNTW-1:0]  cnt_q [WIDTH];
        logic [CNTW-1:0]  cnt_d [WIDTH];
        logic [WIDTH-1:0] out_q;
        logic [WIDTH-1:0] mask_q;
        logic [WIDTH-1:0] status_q;
        logic [WIDTH-1:0] status_d;
        logic [WIDTH-1:0] toggle;
        logic [WIDTH-1:0] clr;

        // Out-of-range channel numbers never match any generated channel,
        // so writes to them fall on the floor without extra logic.
        assign ch_hit[c] = (addr_ch == AW'(c));
        assign wr_hit    = wr_en && ch_hit[c];

        // Synchroniser chain; s is the metastability-safe copy of the pins.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                // NOTE: state is updated with <= so every flop samples the
                // pre-edge value of its neighbour; = here would collapse the
                // chain into a single stage.
                sync_q[0] <= gpio_in[c*WIDTH +: WIDTH];
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Debounce: a bit of IN follows s only after s has disagreed with
        // it for DEBOUNCE consecutive cycles; any agreement restarts the count.
        always_comb begin
            // NOTE: every output of this block gets a default first, so no
            // path leaves a value unassigned and no latch is inferred.
            in_d = in_q;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_d[b] = cnt_q[b];
                if (s[b] == in_q[b]) begin
                    cnt_d[b] = '0;
                end else if (cnt_q[b] == CNT_MAX) begin
                    in_d[b]  = s[b];
                    cnt_d[b] = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end

        // STATUS: a new edge on the same cycle as a W1C wins, so the clear
        // mask is applied before OR-ing in this cycle's toggles.
        assign toggle   = in_d ^ in_q;
        assign clr      = (wr_hit && sel == REG_STATUS) ? wdata : '0;
        assign status_d = (status_q & ~clr) | toggle;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                in_q     <= '0;
                out_q    <= '0;
                mask_q   <= '0;
                status_q <= '0;
                // NOTE: the counter array is cleared on reset as well, so a
                // change that was mid-qualification is discarded and must
                // re-qualify with the full latency afterwards.
                for (int b = 0; b < WIDTH; b++) begin
                    cnt_q[b] <= '0;
                end
            end else begin
                in_q     <= in_d;
                status_q <= status_d;
                for (int b = 0; b < WIDTH; b++) begin
                    cnt_q[b] <= cnt_d[b];
                end
                if (wr_hit && sel == REG_OUT) begin
                    out_q <= wdata;
                end
                if (wr_hit && sel == REG_MASK) begin
                    mask_q <= wdata;
                end
            end
        end

        assign out_all   [c*WIDTH +: WIDTH] = out_q;
        assign in_all    [c*WIDTH +: WIDTH] = in_q;
        assign mask_all  [c*WIDTH +: WIDTH] = mask_q;
        assign status_all[c*WIDTH +: WIDTH] = status_q;
        assign ch_irq[c] = |(status_q & mask_q);
    end

    // Read mux; an unmatched channel leaves the zero default in place.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_hit[c]) begin
                case (sel)
                    REG_OUT:    rd_mux = out_all   [c*WIDTH +: WIDTH];
                    REG_IN:     rd_mux = in_all    [c*WIDTH +: WIDTH];
                    REG_MASK:   rd_mux = mask_all  [c*WIDTH +: WIDTH];
                    REG_STATUS: rd_mux = status_all[c*WIDTH +: WIDTH];
                    default:    rd_mux = '0;
                endcase
            end
        end
    end

    // Registered read port; the mux sees pre-write register values, so a
    // read and write to the same address on one edge returns the old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= rd_mux;
            end
        end
    end

    assign gpio_out = out_all;
    assign irq      = |ch_irq;

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Parametrised multi-channel GPIO peripheral; successor to the single fixed-width GPIO_in/GPIO_out pair on the cpu.
Each channel provides:
- a CPU-writable output register;
- a synchronised, debounced input register;
- per-bit edge detection with a write-1-to-clear status register and a maskable interrupt.
Sits between the cpu's load/store path and the board pins (switches, LEDs, hex displays).

Parameters:
WIDTH, 32, bits per channel (1..32)
CHANNELS, 2, number of independent channels (1..8)
SYNC_STAGES, 2, input synchroniser flops per bit (>=2)
DEBOUNCE, 4, consecutive stable cycles needed to accept an input change (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
gpio_in  in  CHANNELS*WIDTH  raw pins; channel c = bits [c*WIDTH +: WIDTH]
gpio_out  out  CHANNELS*WIDTH  registered output pins, same packing
wr_en  in  1  register write strobe
rd_en  in  1  register read strobe
addr  in  AW=$clog2(CHANNELS)+2  [1:0] register select, [AW-1:2] channel
wdata  in  WIDTH  write data
rdata  out  WIDTH  read data, valid when rvalid=1
rvalid  out  1  one-cycle pulse, one cycle after an accepted rd_en
irq  out  1  OR over channels of (STATUS & MASK)

Behaviour:
- Reset (async assert): all of the following clear to 0 immediately: gpio_out, rdata, rvalid, irq, sync flops, debounced IN, debounce counters, MASK, STATUS.
- Reset deassertion is synchronous to clk at system level; first functional edge is the next rising clk.
- Register map per channel:
  - 0 OUT: rw, drives gpio_out.
  - 1 IN: ro, debounced input; writes ignored.
  - 2 MASK: rw.
  - 3 STATUS: W1C; wdata bit=1 clears that bit.
- Write: takes effect on the clk edge where wr_en=1. OUT change is visible on gpio_out after that same edge.
- Read: on an edge with rd_en=1, rdata is registered from the currently selected register and rvalid=1 for exactly one cycle. When rd_en=0, rvalid=0 and rdata holds its last value.
- Read and write to the same address on the same edge: read returns the pre-write value.
- Out-of-range channel (channel index >= CHANNELS): write ignored; read returns 0 with rvalid=1.
- Synchroniser: per bit, a SYNC_STAGES-deep flop chain; s = last stage output.
- Debounce, per bit, counter cnt with range 0..DEBOUNCE-1:
  - if s == IN: cnt <= 0;
  - else if cnt == DEBOUNCE-1: IN <= s, cnt <= 0;
  - else cnt <= cnt+1.
  - A pin change held steady appears in IN exactly SYNC_STAGES+DEBOUNCE edges after first sampled.
  - Pulses shorter than DEBOUNCE cycles at s are rejected.
- Edge detect: on the edge where an IN bit toggles (either direction), the same STATUS bit is set on that edge. STATUS bits set regardless of MASK.
- STATUS set and W1C clear of the same bit on the same edge: set wins (bit ends at 1).
- irq: combinational from STATUS & MASK. Writing MASK=0 drops irq immediately after the write edge without clearing STATUS.
- Reset mid-debounce: the pending change is discarded. After release, IN re-qualifies from 0 using the full latency.
- Pins held at 0 through reset produce no STATUS set.

Test Plan:
1. Reset: hold rst=1 with gpio_in=all 1s, pulse clk -> gpio_out=0, irq=0, rvalid=0; read IN ch0 after release -> 0 until 6 edges of pins stable, then 0xFFFFFFFF.
2. OUT write/readback: write addr=3'b100 (ch1 OUT) wdata=0x0000_0011 -> gpio_out[63:32]=0x11 after edge; read same addr -> rvalid pulse next cycle, rdata=0x11; gpio_out[31:0] stays 0.
3. Debounce (SYNC_STAGES=2, DEBOUNCE=4):
   - 3-cycle high glitch on gpio_in[0] -> IN ch0 stays 0, STATUS ch0 stays 0.
   - step held high -> IN bit0=1 exactly 6 edges after the step, STATUS bit0=1 on that same edge.
4. Interrupt/W1C: MASK ch0=0x1, bit0 rises -> irq=1. Write STATUS ch0 wdata=0x1 -> STATUS=0, irq=0 after edge. Falling edge later -> irq=1 again.
5. Set-vs-clear collision: schedule W1C of STATUS bit0 on the exact edge IN bit0 toggles -> STATUS bit0=1, irq stays 1.
6. Out-of-range and IN write: with CHANNELS=3, write then read channel 3 OUT -> rdata=0, gpio_out unchanged. Write IN ch0 with 0xFFFF -> IN unchanged.
